// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
// Sits behind the two virtual-channel FIFOs. Each cycle it chooses at most one
// FIFO to pop (VC0 first, with a bounded burst so VC1 cannot starve), captures
// the word returned one cycle later and pushes it into D0 or D1 according to
// one destination bit of the word. New pops stop while either destination is
// almost full; words already popped always complete.
module vc_pop_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4,
  parameter int VC1_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 idle,
  output logic [7:0]           cnt_d0,
  output logic [7:0]           cnt_d1
);

  // Width of the starvation counter: must hold the value VC1_BURST.
  localparam int SW = $clog2(VC1_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(VC1_BURST);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Control state
  state_t              state_r;
  state_t              state_nxt_s;
  logic [SW-1:0]       starve_cnt_r;
  logic [SW-1:0]       starve_nxt_s;

  // Grant decision for the current cycle
  logic                pop_vc0_s;
  logic                pop_vc1_s;
  logic                pause_s;
  logic                vc1_due_s;

  // One-deep in-flight tracking: the FIFO returns data one cycle after a pop
  logic                inflight_v_r;
  logic                inflight_vc_r;
  logic [DATA_SIZE-1:0] word_s;
  logic                dest_s;

  // Registered destination side
  logic                push_d0_r;
  logic                push_d1_r;
  logic [DATA_SIZE-1:0] data_d0_r;
  logic [DATA_SIZE-1:0] data_d1_r;
  logic [7:0]          cnt_d0_r;
  logic [7:0]          cnt_d1_r;

  // Either destination nearing full stops new pops; in-flight words still land
  // because the destination thresholds reserve room for two more entries.
  assign pause_s = pause_d0 | pause_d1;

  // VC1 has waited the full burst of VC0 grants and still has data.
  assign vc1_due_s = (starve_cnt_r == STARVE_MAX) && !fifo_empty_vc1;

  // Next-state and grant decode; grant rules are the same in IDLE and ACTIVE.
  always_comb begin
    state_nxt_s = state_r;
    pop_vc0_s   = 1'b0;
    pop_vc1_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (pause_s) begin
          pop_vc0_s = 1'b0;
          pop_vc1_s = 1'b0;
        end else if (!fifo_empty_vc0 && !vc1_due_s) begin
          pop_vc0_s = 1'b1;
        end else if (!fifo_empty_vc1) begin
          pop_vc1_s = 1'b1;
        end else begin
          pop_vc0_s = 1'b0;
          pop_vc1_s = 1'b0;
        end
        if (pop_vc0_s || pop_vc1_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Starvation counter next value: counts VC0 grants taken while VC1 waits.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (fifo_empty_vc1 || pop_vc1_s) begin
      starve_nxt_s = '0;
    end else if (pop_vc0_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_nxt_s = starve_cnt_r + SW'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else begin
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Remember which channel was popped so its returned word is picked next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_v_r  <= 1'b0;
      inflight_vc_r <= 1'b0;
    end else begin
      inflight_v_r  <= pop_vc0_s | pop_vc1_s;
      inflight_vc_r <= pop_vc1_s;
    end
  end

  // Word returned by the FIFO popped last cycle and the destination it selects.
  assign word_s = inflight_vc_r ? data_vc1 : data_vc0;
  assign dest_s = word_s[DEST_BIT];

  // Route the returned word into D0 or D1; the unused side holds its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_d0_r <= 1'b0;
      push_d1_r <= 1'b0;
      data_d0_r <= '0;
      data_d1_r <= '0;
    end else if (inflight_v_r && !dest_s) begin
      push_d0_r <= 1'b1;
      push_d1_r <= 1'b0;
      data_d0_r <= word_s;
    end else if (inflight_v_r) begin
      push_d0_r <= 1'b0;
      push_d1_r <= 1'b1;
      data_d1_r <= word_s;
    end else begin
      push_d0_r <= 1'b0;
      push_d1_r <= 1'b0;
    end
  end

  // Delivery counters step on the same edge that registers the push; they wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_d0_r <= 8'd0;
      cnt_d1_r <= 8'd0;
    end else if (inflight_v_r && !dest_s) begin
      cnt_d0_r <= cnt_d0_r + 8'd1;
    end else if (inflight_v_r) begin
      cnt_d1_r <= cnt_d1_r + 8'd1;
    end else begin
      cnt_d0_r <= cnt_d0_r;
      cnt_d1_r <= cnt_d1_r;
    end
  end

  assign pop_vc0 = pop_vc0_s;
  assign pop_vc1 = pop_vc1_s;
  assign push_d0 = push_d0_r;
  assign push_d1 = push_d1_r;
  assign data_d0 = data_d0_r;
  assign data_d1 = data_d1_r;
  assign cnt_d0  = cnt_d0_r;
  assign cnt_d1  = cnt_d1_r;

  // Quiescent when nothing is queued, nothing is in flight and no push is
  // showing; reported as idle while reset is held as well.
  assign idle = reset |
                (fifo_empty_vc0 & fifo_empty_vc1 & !inflight_v_r &
                 !push_d0_r & !push_d1_r & (state_r != ST_INIT));

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: queue-based models of the two VC FIFOs
// (registered pop data), a negedge monitor that logs grants and pushes with
// their cycle numbers, and one task per scenario with inline checks.
module tb_vc_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty_vc0 = 1'b1;
  logic       fifo_empty_vc1 = 1'b1;
  logic [5:0] data_vc0 = 6'd0;
  logic [5:0] data_vc1 = 6'd0;
  logic       pause_d0 = 1'b0;
  logic       pause_d1 = 1'b0;
  logic       pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [5:0] data_d0, data_d1;
  logic [7:0] cnt_d0, cnt_d1;

  vc_pop_arbiter #(.DATA_SIZE(6), .DEST_BIT(4), .VC1_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .idle(idle), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  always #5 clk = ~clk;

  // FIFO contents, grant log and push log
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic       p0_n = 1'b0;
  logic       p1_n = 1'b0;
  int         cyc = 0;
  int         gvc[$];
  int         gcyc[$];
  int         pdst[$];
  int         pcyc[$];
  logic [5:0] pdat[$];
  int         idle_rise = -1;
  logic       idle_prev = 1'b1;
  int         bad_pop = 0;
  int         errors = 0;
  int         checks = 0;

  // FIFO models: pop data registered one cycle after the strobe seen last negedge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (p0_n && q0.size() > 0) data_vc0 <= q0.pop_front();
    if (p1_n && q1.size() > 0) data_vc1 <= q1.pop_front();
    fifo_empty_vc0 <= (q0.size() == 0);
    fifo_empty_vc1 <= (q1.size() == 0);
  end

  // Monitor: sample strobes mid-cycle and log them with the cycle number
  always @(negedge clk) begin
    p0_n = pop_vc0;
    p1_n = pop_vc1;
    if ((pop_vc0 && fifo_empty_vc0) || (pop_vc1 && fifo_empty_vc1) || (pop_vc0 && pop_vc1))
      bad_pop = bad_pop + 1;
    if (pop_vc0) begin gvc.push_back(0); gcyc.push_back(cyc); end
    if (pop_vc1) begin gvc.push_back(1); gcyc.push_back(cyc); end
    if (push_d0) begin pdst.push_back(0); pdat.push_back(data_d0); pcyc.push_back(cyc); end
    if (push_d1) begin pdst.push_back(1); pdat.push_back(data_d1); pcyc.push_back(cyc); end
    if (idle && !idle_prev) idle_rise = cyc;
    idle_prev = idle;
  end

  task automatic clear_logs();
    gvc.delete(); gcyc.delete(); pdst.delete(); pcyc.delete(); pdat.delete();
    idle_rise = -1;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && idle === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: idle=%b q0=%0d q1=%0d, required idle within %0d cycles",
               tag, idle, q0.size(), q1.size(), budget);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (push_d0 !== 1'b0 || push_d1 !== 1'b0) begin errors++; $display("FAIL rst_push: got %b%b, required 00", push_d0, push_d1); end
    checks++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b%b, required 00", pop_vc0, pop_vc1); end
    checks++; if (data_d0 !== 6'h00 || data_d1 !== 6'h00) begin errors++; $display("FAIL rst_data: got %h/%h, required 00/00", data_d0, data_d1); end
    checks++; if (cnt_d0 !== 8'd0 || cnt_d1 !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d, required 0/0", cnt_d0, cnt_d1); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b, required 1", idle); end
    reset = 1'b0;
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL init_idle: got %b, required 0 in INIT", idle); end
    @(posedge clk); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_init_idle: got %b, required 1", idle); end
  endtask

  task automatic test_basic_route();
    logic [5:0] ew[3] = '{6'h01, 6'h11, 6'h02};
    int ed[3] = '{0, 1, 0};
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 3; i++) q0.push_back(ew[i]);
    wait_quiet(40, "basic");
    checks++;
    if (gvc.size() != 3 || pdst.size() != 3) begin
      errors++; $display("FAIL basic_counts: grants=%0d pushes=%0d, required 3/3", gvc.size(), pdst.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gvc[i] != 0 || gcyc[i] != gcyc[0] + i) begin
          errors++; $display("FAIL basic_grant%0d: vc=%0d cyc=%0d, required vc=0 cyc=%0d", i, gvc[i], gcyc[i], gcyc[0] + i);
        end
        checks++;
        if (pdst[i] != ed[i] || pdat[i] !== ew[i] || pcyc[i] != gcyc[0] + 2 + i) begin
          errors++; $display("FAIL basic_push%0d: d=%0d data=%h cyc=%0d, required d=%0d data=%h cyc=%0d",
                             i, pdst[i], pdat[i], pcyc[i], ed[i], ew[i], gcyc[0] + 2 + i);
        end
      end
    end
    checks++; if (cnt_d0 !== 8'd2 || cnt_d1 !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d/%0d, required 2/1", cnt_d0, cnt_d1); end
  endtask

  task automatic test_priority_burst();
    int ev[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    logic [5:0] ew[12];
    int i0 = 0;
    int i1 = 0;
    for (int k = 0; k < 12; k++) begin
      if (ev[k] == 0) begin ew[k] = 6'(i0); i0++; end
      else begin ew[k] = 6'h30 + 6'(i1); i1++; end
    end
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 10; i++) q0.push_back(6'(i));
    q1.push_back(6'h30); q1.push_back(6'h31);
    wait_quiet(60, "prio");
    checks++;
    if (gvc.size() != 12 || pdst.size() != 12) begin
      errors++; $display("FAIL prio_counts: grants=%0d pushes=%0d, required 12/12", gvc.size(), pdst.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (gvc[k] != ev[k] || gcyc[k] != gcyc[0] + k) begin
          errors++; $display("FAIL prio_grant%0d: vc=%0d cyc=%0d, required vc=%0d cyc=%0d", k, gvc[k], gcyc[k], ev[k], gcyc[0] + k);
        end
        checks++;
        if (pdat[k] !== ew[k] || pdst[k] != ev[k] || pcyc[k] != gcyc[k] + 2) begin
          errors++; $display("FAIL prio_push%0d: data=%h d=%0d cyc=%0d, required data=%h d=%0d cyc=%0d",
                             k, pdat[k], pdst[k], pcyc[k], ew[k], ev[k], gcyc[k] + 2);
        end
      end
    end
    checks++; if (cnt_d0 !== 8'd12 || cnt_d1 !== 8'd3) begin errors++; $display("FAIL prio_cnt: got %0d/%0d, required 12/3", cnt_d0, cnt_d1); end
  endtask

  task automatic test_pause();
    int rel;
    @(posedge clk); #1;
    clear_logs();
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07); q0.push_back(6'h08);
    q1.push_back(6'h35); q1.push_back(6'h36);
    repeat (3) @(posedge clk);
    #1;
    pause_d1 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin
        errors++; $display("FAIL pause_pop: got %b%b at cycle %0d, required 00", pop_vc0, pop_vc1, cyc);
      end
    end
    @(posedge clk); #1;
    pause_d1 = 1'b0;
    rel = cyc;
    checks++; if (gvc.size() != 2) begin errors++; $display("FAIL pause_grants: got %0d, required 2", gvc.size()); end
    checks++;
    if (pdat.size() != 2) begin
      errors++; $display("FAIL pause_drain: pushes=%0d, required 2", pdat.size());
    end else if (pdat[0] !== 6'h05 || pdat[1] !== 6'h06) begin
      errors++; $display("FAIL pause_drain: data=%h,%h, required 05,06", pdat[0], pdat[1]);
    end
    wait_quiet(40, "pause");
    checks++;
    if (gvc.size() != 6) begin
      errors++; $display("FAIL pause_total: grants=%0d, required 6", gvc.size());
    end else if (gcyc[2] != rel) begin
      errors++; $display("FAIL pause_resume: first grant cycle %0d, required %0d", gcyc[2], rel);
    end
    checks++; if (cnt_d0 !== 8'd16 || cnt_d1 !== 8'd5) begin errors++; $display("FAIL pause_cnt: got %0d/%0d, required 16/5", cnt_d0, cnt_d1); end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    clear_logs();
    q1.push_back(6'h3A);
    @(posedge clk); #1;
    checks++; if (pop_vc1 !== 1'b1) begin errors++; $display("FAIL rif_pop: pop_vc1=%b, required 1", pop_vc1); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (push_d0 !== 1'b0 || push_d1 !== 1'b0 || pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin
      errors++; $display("FAIL rif_strobes: push=%b%b pop=%b%b, required 0000", push_d0, push_d1, pop_vc0, pop_vc1); end
    checks++; if (data_d0 !== 6'h00 || data_d1 !== 6'h00 || cnt_d0 !== 8'd0 || cnt_d1 !== 8'd0) begin
      errors++; $display("FAIL rif_regs: data=%h/%h cnt=%0d/%0d, required all 0", data_d0, data_d1, cnt_d0, cnt_d1); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rif_idle: got %b, required 1", idle); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (pdst.size() != 0) begin errors++; $display("FAIL rif_nopush: pushes=%0d, required 0", pdst.size()); end
    checks++; if (idle !== 1'b1 || cnt_d1 !== 8'd0) begin errors++; $display("FAIL rif_after: idle=%b cnt_d1=%0d, required 1/0", idle, cnt_d1); end
  endtask

  task automatic test_wrap();
    bit hit = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 256; i++) q0.push_back(6'(i & 15));
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk); #1;
      if (pdst.size() >= 255) hit = 1'b1;
    end
    checks++;
    if (!hit || cnt_d0 !== 8'd255) begin
      errors++; $display("FAIL wrap_255: pushes=%0d cnt_d0=%0d, required 255/255", pdst.size(), cnt_d0);
    end
    wait_quiet(40, "wrap");
    checks++; if (cnt_d0 !== 8'd0 || cnt_d1 !== 8'd0) begin errors++; $display("FAIL wrap_cnt: got %0d/%0d, required 0/0", cnt_d0, cnt_d1); end
    checks++; if (pdst.size() != 256 || data_d0 !== 6'h0F) begin
      errors++; $display("FAIL wrap_total: pushes=%0d last=%h, required 256/0f", pdst.size(), data_d0); end
  endtask

  task automatic test_vc1_single();
    @(posedge clk); #1;
    clear_logs();
    q1.push_back(6'h12);
    wait_quiet(20, "vc1");
    checks++;
    if (gvc.size() != 1 || pdst.size() != 1) begin
      errors++; $display("FAIL vc1_counts: grants=%0d pushes=%0d, required 1/1", gvc.size(), pdst.size());
    end else begin
      checks++;
      if (gvc[0] != 1 || pdst[0] != 1 || pdat[0] !== 6'h12 || pcyc[0] != gcyc[0] + 2) begin
        errors++; $display("FAIL vc1_push: vc=%0d d=%0d data=%h cyc=%0d, required vc=1 d=1 data=12 cyc=%0d",
                           gvc[0], pdst[0], pdat[0], pcyc[0], gcyc[0] + 2);
      end
      checks++;
      if (idle_rise != gcyc[0] + 3) begin
        errors++; $display("FAIL vc1_idle: idle rose at %0d, required %0d", idle_rise, gcyc[0] + 3);
      end
    end
    checks++; if (cnt_d1 !== 8'd1 || cnt_d0 !== 8'd0) begin errors++; $display("FAIL vc1_cnt: got %0d/%0d, required 0/1", cnt_d0, cnt_d1); end
  endtask

  task automatic test_no_empty_pop();
    checks++;
    if (bad_pop !== 0) begin
      errors++; $display("FAIL empty_pop: %0d illegal pop cycles, required 0", bad_pop);
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_priority_burst();
    test_pause();
    test_reset_inflight();
    test_wrap();
    test_vc1_single();
    test_no_empty_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Stage directly downstream of the two virtual-channel FIFOs (VC0, VC1).
- Each cycle it decides which FIFO to pop, captures the word the FIFO returns one cycle later, and routes it to destination FIFO D0 or D1 by a destination bit.
- Arbitration is strict priority VC0 > VC1, with a bounded-burst anti-starvation rule for VC1.
- All pops are gated by the almost-full pause flags from D0/D1.

Parameters:
- DATA_SIZE, 6, word width in bits.
- DEST_BIT, 4, bit index of the word that selects the destination: 0 → D0, 1 → D1.
- VC1_BURST, 4, maximum consecutive VC0 grants while VC1 is non-empty; must be ≥1.

Ports:
- clk  in  1  single clock; all flops on posedge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty_vc0  in  1  VC0 FIFO empty flag.
- fifo_empty_vc1  in  1  VC1 FIFO empty flag.
- data_vc0  in  DATA_SIZE  VC0 FIFO registered pop data; valid the cycle after pop_vc0.
- data_vc1  in  DATA_SIZE  VC1 FIFO registered pop data; valid the cycle after pop_vc1.
- pause_d0  in  1  D0 FIFO almost-full pause.
- pause_d1  in  1  D1 FIFO almost-full pause.
- pop_vc0  out  1  pop strobe to VC0 (combinational from registered state and inputs).
- pop_vc1  out  1  pop strobe to VC1.
- push_d0  out  1  registered push to D0.
- push_d1  out  1  registered push to D1.
- data_d0  out  DATA_SIZE  registered data to D0.
- data_d1  out  DATA_SIZE  registered data to D1.
- idle  out  1  high when both VC FIFOs are empty, nothing is in flight, and no push is pending.
- cnt_d0  out  8  words delivered to D0; wraps modulo 256.
- cnt_d1  out  8  words delivered to D1; wraps modulo 256.

Behaviour:
- Reset (asynchronous, immediate): FSM=INIT; pop_vc0=pop_vc1=0; push_d0=push_d1=0; data_d0=data_d1=0; cnt_d0=cnt_d1=0; starve_cnt=0; inflight_v=0; idle=1.
- Reset asserted mid-transfer discards any in-flight word; no push is issued for it after release.
- FSM states: INIT, IDLE, ACTIVE.
  - INIT: no pops; always → IDLE on the next edge.
  - IDLE ↔ ACTIVE: state is ACTIVE in any cycle following a granted pop, otherwise IDLE.
  - Grant logic is identical in IDLE and ACTIVE.
- Grant, evaluated combinationally in IDLE/ACTIVE:
  - If pause_d0 | pause_d1: no pop.
  - Else if !fifo_empty_vc0 && !(starve_cnt==VC1_BURST && !fifo_empty_vc1): pop_vc0=1.
  - Else if !fifo_empty_vc1: pop_vc1=1.
  - At most one pop per cycle.
- starve_cnt (width $clog2(VC1_BURST+1)):
  - +1 on a VC0 grant while fifo_empty_vc1=0, saturating at VC1_BURST.
  - Cleared on any VC1 grant or whenever fifo_empty_vc1=1.
- In-flight tracking: on the edge ending a grant cycle, set inflight_v=1 and inflight_vc=granted channel; otherwise inflight_v=0.
- Capture/route (in the cycle with inflight_v=1):
  - Select word = inflight_vc ? data_vc1 : data_vc0.
  - On the next edge: if word[DEST_BIT]==0, push_d0<=1, data_d0<=word; else push_d1<=1, data_d1<=word.
  - The push not taken is 0.
  - Data on the unused output holds its last value.
- Latency: pop in cycle N → push in cycle N+2.
  - Back-to-back pops give one push per cycle; throughput is 1 word/cycle.
- Pause:
  - Blocks only new pops.
  - Up to 2 words already popped still complete; D0/D1 almost-full thresholds must reserve ≥2 entries.
- Counters: cnt_dX increments on the edge where push_dX is registered high; 255 → 0 wrap.
- idle = fifo_empty_vc0 & fifo_empty_vc1 & !inflight_v & !push_d0 & !push_d1 & (state!=INIT).
  - idle is also 1 during reset.
- Popping an empty FIFO never occurs by construction; verification asserts this.

Test Plan:
- Reset, then load VC0 with 3 words, dest bits 0,1,0 (e.g. 6'h01, 6'h11, 6'h02) → pops in cycles 1–3; push_d0 with 01 at cycle 3, push_d1 with 11 at cycle 4, push_d0 with 02 at cycle 5; cnt_d0=2, cnt_d1=1.
- VC0 holds 10 words, VC1 holds 2 words, VC1_BURST=4 → grant order 0,0,0,0,1,0,0,0,0,1,0,0; no two consecutive VC1 grants while VC0 is non-empty.
- pause_d1=1 while both VCs are non-empty → no pop while asserted; the ≤2 in-flight words are still pushed; pops resume the cycle pause drops.
- Reset asserted the cycle after pop_vc1 → no push_d0/push_d1 follows; all outputs are 0 immediately; idle=1.
- Deliver 256 words to D0 → cnt_d0 wraps to 0; cnt_d1 unchanged.
- Only VC1 non-empty, 1 word → pop_vc1 at cycle N, push at N+2, idle returns to 1 at N+3.
